key_shift_loader: RTL and testbench

- Sequential key-delivery unit for our XNOR-key-gate-locked combinational benchmarks. It receives a locking key serially, SHIFT_W bits per beat, over a valid/ready handshake and holds it in a shadow register.
- On commit it transfers the shadow key atomically to the key bus that drives the locked netlist's key_* inputs.
- It generalises the fixed 20-input key bus to any key width and beat width, and adds a load-count lockout.

---
 rtl/key_shift_loader_pkg.sv | 20 ++
 rtl/key_shift_loader_if.sv | 26 ++
 rtl/key_shift_loader_shadow.sv | 25 ++
 rtl/key_shift_loader.sv | 111 +++++++++++
 tb/tb_key_shift_loader.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/key_shift_loader_pkg.sv
// klock_pkg: shared state type and beat/counter sizing helpers for the key loader.
package klock_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

    localparam int KEY_W_DEF   = 20;
    localparam int SHIFT_W_DEF = 1;

    function automatic int nbeats(input int kw, input int sw);
        return (kw + sw - 1) / sw;
    endfunction

    // Counter must be able to hold NBEATS itself, not just NBEATS-1.
    function automatic int cnt_w(input int kw, input int sw);
        return $clog2(nbeats(kw, sw) + 1);
    endfunction

    localparam int CNT_W_DEF = cnt_w(KEY_W_DEF, SHIFT_W_DEF);

endpackage

// File: rtl/key_shift_loader_if.sv
// key_shift_loader_if: serial key load handshake plus committed key bus and status.
interface key_shift_loader_if #(
    parameter int KEY_W   = 20,
    parameter int SHIFT_W = 1
);
    logic               load_start;
    logic               load_valid;
    logic [SHIFT_W-1:0] load_data;
    logic               load_ready;
    logic               commit;
    logic [KEY_W-1:0]   key_out;
    logic               key_valid;
    logic               busy;
    logic               err;
    logic               lockout;

    modport master (
        output load_start, load_valid, load_data, commit,
        input  load_ready, key_out, key_valid, busy, err, lockout
    );

    modport slave (
        input  load_start, load_valid, load_data, commit,
        output load_ready, key_out, key_valid, busy, err, lockout
    );
endinterface

// File: rtl/key_shift_loader_shadow.sv
// key_shadow_reg: shadow key register with per-beat indexed write and synchronous clear.
module key_shadow_reg #(
    parameter int KEY_W   = 20,
    parameter int SHIFT_W = 1,
    parameter int CW      = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               we,
    input  logic [CW-1:0]      idx,
    input  logic [SHIFT_W-1:0] din,
    output logic [KEY_W-1:0]   q
);
    // Bits of the final beat beyond KEY_W simply have no storage.
    for (genvar i = 0; i < KEY_W; i++) begin : g_bit
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n)
                q[i] <= 1'b0;
            else if (clr)
                q[i] <= 1'b0;
            else if (we && idx == CW'(i / SHIFT_W))
                q[i] <= din[i % SHIFT_W];
    end
endmodule

// File: rtl/key_shift_loader.sv
// key_shift_loader: serial key shadow load with atomic commit to the locked netlist key bus.
module key_shift_loader
    import klock_pkg::*;
#(
    parameter int               KEY_W     = 20,
    parameter int               SHIFT_W   = 1,
    parameter logic [KEY_W-1:0] KEY_RST   = '0,
    parameter int               MAX_LOADS = 4
) (
    input logic              clk,
    input logic              rst_n,
    key_shift_loader_if.slave bus
);
    localparam int NB = nbeats(KEY_W, SHIFT_W);
    localparam int CW = cnt_w(KEY_W, SHIFT_W);
    localparam int LW = MAX_LOADS > 0 ? $clog2(MAX_LOADS + 1) : 1;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [LW-1:0]    loads_q, loads_d;
    logic [KEY_W-1:0] key_q, key_d, shadow;
    logic             key_valid_q, key_valid_d, err_q, err_d, lock_q, lock_d, busy_q;
    logic             clr, we;

    key_shadow_reg #(.KEY_W(KEY_W), .SHIFT_W(SHIFT_W), .CW(CW)) u_shadow (
        .clk(clk), .rst_n(rst_n), .clr(clr), .we(we),
        .idx(cnt_q), .din(bus.load_data), .q(shadow)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        loads_d     = loads_q;
        key_d       = key_q;
        key_valid_d = key_valid_q;
        err_d       = err_q;
        lock_d      = lock_q;
        clr         = 1'b0;
        we          = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load_start) begin
                    if (lock_q) err_d = 1'b1;
                    else begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        clr     = 1'b1;
                    end
                end
                if (bus.commit) err_d = 1'b1;
            end
            SHIFT: begin
                if (bus.load_start) begin
                    err_d = 1'b1;
                    cnt_d = '0;
                    clr   = 1'b1;
                end else if (bus.load_valid) begin
                    we    = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(NB - 1)) state_d = FULL;
                end
                if (bus.commit) err_d = 1'b1;
            end
            FULL: begin
                // Commit wins over a simultaneous load_start, leaving err alone.
                if (bus.commit) begin
                    key_d       = shadow;
                    key_valid_d = 1'b1;
                    loads_d     = loads_q + 1'b1;
                    state_d     = IDLE;
                    if (MAX_LOADS != 0 && loads_d == LW'(MAX_LOADS)) lock_d = 1'b1;
                end else if (bus.load_start) begin
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    clr     = 1'b1;
                    state_d = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            loads_q     <= '0;
            key_q       <= KEY_RST;
            key_valid_q <= 1'b0;
            err_q       <= 1'b0;
            lock_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loads_q     <= loads_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            err_q       <= err_d;
            lock_q      <= lock_d;
            busy_q      <= state_d != IDLE;
        end

    assign bus.load_ready = state_q == SHIFT;
    assign bus.key_out    = key_q;
    assign bus.key_valid  = key_valid_q;
    assign bus.err        = err_q;
    assign bus.lockout    = lock_q;
    assign bus.busy       = busy_q;
endmodule

// File: tb/tb_key_shift_loader.sv
// tb_key_shift_loader: directed, table-driven and model-checked random tests for key_shift_loader.
module tb_key_shift_loader;

    typedef struct {
        logic [23:0] beats;
        logic [19:0] exp;
    } vec_t;

    logic clk, rst_na, rst_nb;
    int   checks, failures;

    key_shift_loader_if #(.KEY_W(20), .SHIFT_W(1)) ia ();
    key_shift_loader_if #(.KEY_W(20), .SHIFT_W(8)) ib ();

    key_shift_loader #(.KEY_W(20), .SHIFT_W(1), .KEY_RST(20'h0), .MAX_LOADS(0)) dut_a (
        .clk(clk), .rst_n(rst_na), .bus(ia)
    );
    key_shift_loader #(.KEY_W(20), .SHIFT_W(8), .KEY_RST(20'hC0FFE), .MAX_LOADS(2)) dut_b (
        .clk(clk), .rst_n(rst_nb), .bus(ib)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic a_load(input logic [19:0] k);
        ia.load_start = 1'b1;
        step;
        ia.load_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ia.load_valid = 1'b1;
            ia.load_data  = k[i];
            step;
        end
        ia.load_valid = 1'b0;
    endtask

    task automatic a_commit;
        ia.commit = 1'b1;
        step;
        ia.commit = 1'b0;
    endtask

    vec_t        tbl [4];
    logic [19:0] mkey, msh;
    logic        mkv, merr, mact, mfull;
    int          mcnt;

    initial begin
        checks   = 0;
        failures = 0;
        tbl[0] = '{24'hFA5C3F, 20'hA5C3F};
        tbl[1] = '{24'hF30201, 20'h30201};
        tbl[2] = '{24'h0F00FF, 20'hF00FF};
        tbl[3] = '{24'h7055AA, 20'h055AA};
        {ia.load_start, ia.load_valid, ia.load_data, ia.commit} = '0;
        {ib.load_start, ib.load_valid, ib.load_data, ib.commit} = '0;
        rst_na = 1'b0;
        rst_nb = 1'b0;
        step;
        step;
        rst_na = 1'b1;
        rst_nb = 1'b1;

        chk("rst_key", 32'(ia.key_out), 32'h0);
        chk("rst_kv", 32'(ia.key_valid), 32'h0);
        chk("rst_ready", 32'(ia.load_ready), 32'h0);
        chk("rst_busy", 32'(ia.busy), 32'h0);
        chk("rst_err", 32'(ia.err), 32'h0);
        chk("rst_lock", 32'(ia.lockout), 32'h0);
        chk("rst_key_b", 32'(ib.key_out), 32'hC0FFE);

        a_load(20'hA5C3F);
        chk("full_ready", 32'(ia.load_ready), 32'h0);
        chk("full_busy", 32'(ia.busy), 32'h1);
        chk("full_key_hidden", 32'(ia.key_out), 32'h0);
        a_commit;
        chk("w1_key", 32'(ia.key_out), 32'hA5C3F);
        chk("w1_kv", 32'(ia.key_valid), 32'h1);
        chk("w1_busy", 32'(ia.busy), 32'h0);

        a_load(20'h12345);
        a_commit;
        chk("c2_key", 32'(ia.key_out), 32'h12345);
        ia.load_start = 1'b1;
        step;
        ia.load_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ia.load_valid = 1'b1;
            ia.load_data  = 1'b1;
            step;
        end
        ia.load_valid = 1'b0;
        ia.load_start = 1'b1;
        step;
        ia.load_start = 1'b0;
        chk("abort_err", 32'(ia.err), 32'h1);
        chk("abort_busy", 32'(ia.busy), 32'h1);
        chk("abort_key", 32'(ia.key_out), 32'h12345);
        chk("abort_kv", 32'(ia.key_valid), 32'h1);
        a_commit;
        chk("shift_commit_err", 32'(ia.err), 32'h1);
        chk("shift_commit_key", 32'(ia.key_out), 32'h12345);
        chk("shift_commit_ready", 32'(ia.load_ready), 32'h1);

        #3 rst_na = 1'b0;
        #1;
        chk("async_key", 32'(ia.key_out), 32'h0);
        chk("async_kv", 32'(ia.key_valid), 32'h0);
        chk("async_busy", 32'(ia.busy), 32'h0);
        chk("async_err", 32'(ia.err), 32'h0);
        step;
        rst_na = 1'b1;

        a_load(20'h5A5A5);
        chk("pre_both_err", 32'(ia.err), 32'h0);
        ia.load_start = 1'b1;
        ia.commit     = 1'b1;
        step;
        ia.load_start = 1'b0;
        ia.commit     = 1'b0;
        chk("both_key", 32'(ia.key_out), 32'h5A5A5);
        chk("both_err", 32'(ia.err), 32'h0);
        chk("both_busy", 32'(ia.busy), 32'h0);
        chk("both_ready", 32'(ia.load_ready), 32'h0);
        step;
        chk("both_idle", 32'(ia.busy), 32'h0);

        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                rst_nb = 1'b0;
                #2 rst_nb = 1'b1;
            end
            ib.load_start = 1'b1;
            step;
            ib.load_start = 1'b0;
            for (int j = 0; j < 3; j++) begin
                ib.load_valid = 1'b1;
                ib.load_data  = tbl[i].beats[j*8 +: 8];
                step;
            end
            ib.load_valid = 1'b0;
            chk("tbl_ready", 32'(ib.load_ready), 32'h0);
            ib.commit = 1'b1;
            step;
            ib.commit = 1'b0;
            chk("tbl_key", 32'(ib.key_out), 32'(tbl[i].exp));
            chk("tbl_kv", 32'(ib.key_valid), 32'h1);
            chk("tbl_err", 32'(ib.err), 32'h0);
            chk("tbl_lock", 32'(ib.lockout), 32'(i % 2));
        end
        ib.load_start = 1'b1;
        step;
        ib.load_start = 1'b0;
        chk("lock_err", 32'(ib.err), 32'h1);
        chk("lock_busy", 32'(ib.busy), 32'h0);
        chk("lock_ready", 32'(ib.load_ready), 32'h0);
        chk("lock_key", 32'(ib.key_out), 32'h055AA);
        #3 rst_nb = 1'b0;
        #1;
        chk("b_async_key", 32'(ib.key_out), 32'hC0FFE);
        chk("b_async_lock", 32'(ib.lockout), 32'h0);
        chk("b_async_kv", 32'(ib.key_valid), 32'h0);
        step;
        rst_nb = 1'b1;

        rst_na = 1'b0;
        #2 rst_na = 1'b1;
        mkey = '0;
        msh  = '0;
        mkv  = 1'b0;
        merr = 1'b0;
        mact = 1'b0;
        mcnt = 0;
        for (int n = 0; n < 3000; n++) begin
            ia.load_start = $urandom_range(0, 49) == 0;
            ia.commit     = $urandom_range(0, 19) == 0;
            ia.load_valid = $urandom_range(0, 3) != 0;
            ia.load_data  = 1'($urandom);
            mfull = mact && mcnt == 20;
            if (mfull && ia.commit) begin
                mkey = msh;
                mkv  = 1'b1;
                mact = 1'b0;
            end else begin
                if (ia.load_start) begin
                    merr = mact;
                    mact = 1'b1;
                    mcnt = 0;
                    msh  = '0;
                end else if (mact && !mfull && ia.load_valid) begin
                    msh[mcnt] = ia.load_data;
                    mcnt++;
                end
                if (ia.commit) merr = 1'b1;
            end
            step;
            chk("rnd_key", 32'(ia.key_out), 32'(mkey));
            chk("rnd_kv", 32'(ia.key_valid), 32'(mkv));
            chk("rnd_err", 32'(ia.err), 32'(merr));
            chk("rnd_busy", 32'(ia.busy), 32'(mact));
            chk("rnd_ready", 32'(ia.load_ready), 32'(mact && mcnt < 20));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
